cook_timer: RTL and testbench

- Upstream stage of the magnetron enable latch: holds the keypad-entered cook time as four BCD digits (MM:SS) and counts it down once per second while the magnetron is on.
- Produces `timer_done`, which the magnetron latch consumes as a reset term.
- Takes the latch's Q output back as `mag_on` to gate the countdown, so stop or door-open pauses cooking with the remaining time kept.

---
 rtl/cook_timer.sv | 170 +++++++++++++++++
 tb/tb_cook_timer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer.sv
// Four-digit BCD (MM:SS) cook timer that counts down once per second while the magnetron latch is on.
// Optional macro ADD_MINUTE_EN adds the i_add_minute strobe (+1 minute, saturating at 99).
module cook_timer #(
  parameter int TICKS_PER_SEC = 1000000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_clearn,
  input  logic       i_digit_valid,
  input  logic [3:0] i_digit,
  input  logic       i_mag_on,
`ifdef ADD_MINUTE_EN
  input  logic       i_add_minute,
`endif
  output logic       o_timer_done,
  output logic       o_running,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic [1:0] o_state
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SET  = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t        r_state;
  logic [3:0]    r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [PW-1:0] r_presc;
  logic          r_done;
  logic          r_running;

  state_t        w_next;
  logic [3:0]    w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;
  logic [PW-1:0] w_presc;
  logic          w_entry;

  logic [3:0]    w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones;
  logic          w_dec_zero;

  // One-second BCD decrement; seconds tens borrows to 5, so 0:90 counts 89, 88, ...
  always_comb begin
    w_dec_min_tens = r_min_tens;
    w_dec_min_ones = r_min_ones;
    w_dec_sec_tens = r_sec_tens;
    w_dec_sec_ones = r_sec_ones - 4'd1;
    if (r_sec_ones == 4'd0) begin
      w_dec_sec_ones = 4'd9;
      if (r_sec_tens == 4'd0) begin
        w_dec_sec_tens = 4'd5;
        if (r_min_ones == 4'd0) begin
          w_dec_min_ones = 4'd9;
          w_dec_min_tens = r_min_tens - 4'd1;
        end else begin
          w_dec_min_ones = r_min_ones - 4'd1;
        end
      end else begin
        w_dec_sec_tens = r_sec_tens - 4'd1;
      end
    end
    w_dec_zero = ({w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones} == 16'd0);
  end

  always_comb begin
    w_next     = r_state;
    w_min_tens = r_min_tens;
    w_min_ones = r_min_ones;
    w_sec_tens = r_sec_tens;
    w_sec_ones = r_sec_ones;
    w_presc    = r_presc;
    w_entry    = i_digit_valid && (i_digit <= 4'd9) && (r_state != RUN);

    if (!i_clearn) begin
      w_next     = IDLE;
      w_min_tens = 4'd0;
      w_min_ones = 4'd0;
      w_sec_tens = 4'd0;
      w_sec_ones = 4'd0;
      w_presc    = '0;
    end else if (w_entry) begin
      w_min_tens = r_min_ones;
      w_min_ones = r_sec_tens;
      w_sec_tens = r_sec_ones;
      w_sec_ones = i_digit;
      w_presc    = '0;
      w_next     = ({r_min_ones, r_sec_tens, r_sec_ones, i_digit} != 16'd0) ? SET : IDLE;
    end else begin
      case (r_state)
        SET: begin
          if (i_mag_on) w_next = RUN;
        end
        RUN: begin
          if (!i_mag_on) begin
            w_next = SET;
          end else if (r_presc == LAST_TICK) begin
            w_presc    = '0;
            w_min_tens = w_dec_min_tens;
            w_min_ones = w_dec_min_ones;
            w_sec_tens = w_dec_sec_tens;
            w_sec_ones = w_dec_sec_ones;
            if (w_dec_zero) w_next = DONE;
          end else begin
            w_presc = r_presc + PW'(1);
          end
        end
        default: begin
          w_next = r_state;
        end
      endcase
    end

`ifdef ADD_MINUTE_EN
    // The added minute lands on top of any same-cycle decrement, so it can rescue a finishing run.
    if (i_clearn && i_add_minute && !w_entry && (r_state != DONE)) begin
      if (!((w_min_tens == 4'd9) && (w_min_ones == 4'd9))) begin
        if (w_min_ones == 4'd9) begin
          w_min_ones = 4'd0;
          w_min_tens = w_min_tens + 4'd1;
        end else begin
          w_min_ones = w_min_ones + 4'd1;
        end
      end
      if (r_state == IDLE) begin
        w_next = SET;
      end else if (w_next == DONE) begin
        w_next = RUN;
      end
    end
`endif
  end

  // timer_done rises one cycle after entering DONE but drops on the same edge that leaves it.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= IDLE;
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_presc    <= '0;
      r_done     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_min_tens <= w_min_tens;
      r_min_ones <= w_min_ones;
      r_sec_tens <= w_sec_tens;
      r_sec_ones <= w_sec_ones;
      r_presc    <= w_presc;
      r_done     <= (r_state == DONE) && (w_next == DONE);
      r_running  <= (w_next == RUN);
    end
  end

  assign o_state      = r_state;
  assign o_timer_done = r_done;
  assign o_running    = r_running;
  assign o_min_tens   = r_min_tens;
  assign o_min_ones   = r_min_ones;
  assign o_sec_tens   = r_sec_tens;
  assign o_sec_ones   = r_sec_ones;

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer: directed scenarios plus random stimulus against a
// decimal-arithmetic reference model. Define ADD_MINUTE_EN to exercise the add-minute strobe.
module tb_cook_timer;

  localparam int TICKS = 4;
  localparam int S_IDLE = 0;
  localparam int S_SET  = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;

  logic       clk;
  logic       resetn;
  logic       clearn;
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
`ifdef ADD_MINUTE_EN
  logic       add_minute;
`endif
  logic       timer_done;
  logic       running;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;

  logic [19:0] obs;
  assign obs = {state, min_tens, min_ones, sec_tens, sec_ones, timer_done, running};

  int total = 0;
  int bad = 0;

  // Model: time as a 4-digit decimal number MMSS, plus elapsed cycles in the current second.
  int m_state;
  int m_val;
  int m_presc;
  bit m_done;
  bit m_run;

  cook_timer #(.TICKS_PER_SEC(TICKS)) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_clearn      (clearn),
    .i_digit_valid (digit_valid),
    .i_digit       (digit),
    .i_mag_on      (mag_on),
`ifdef ADD_MINUTE_EN
    .i_add_minute  (add_minute),
`endif
    .o_timer_done  (timer_done),
    .o_running     (running),
    .o_min_tens    (min_tens),
    .o_min_ones    (min_ones),
    .o_sec_tens    (sec_tens),
    .o_sec_ones    (sec_ones),
    .o_state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [19:0] mk(input int st, input int v, input bit dn, input bit rn);
    mk = {2'(st), 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), dn, rn};
  endfunction

  function automatic logic [19:0] exp_vec();
    exp_vec = mk(m_state, m_val, m_done, m_run);
  endfunction

  function automatic int minus_one_sec(input int v);
    int m, s;
    m = v / 100;
    s = v % 100;
    if (s == 0) begin
      s = 59;
      m = m - 1;
    end else begin
      s = s - 1;
    end
    minus_one_sec = m * 100 + s;
  endfunction

  task automatic model_step(input bit clr, input bit dv, input int d, input bit mag, input bit add);
    int prev;
    bit entry;
    prev = m_state;
    entry = clr && dv && (d <= 9) && (prev != S_RUN);
    if (!clr) begin
      m_state = S_IDLE;
      m_val = 0;
      m_presc = 0;
    end else if (entry) begin
      m_val = (m_val * 10 + d) % 10000;
      m_presc = 0;
      m_state = (m_val != 0) ? S_SET : S_IDLE;
    end else if (prev == S_SET) begin
      if (mag) m_state = S_RUN;
    end else if (prev == S_RUN) begin
      if (!mag) begin
        m_state = S_SET;
      end else if (m_presc == TICKS - 1) begin
        m_presc = 0;
        m_val = minus_one_sec(m_val);
        if (m_val == 0) m_state = S_DONE;
      end else begin
        m_presc++;
      end
    end
    if (clr && add && !entry && (prev != S_DONE)) begin
      if (m_val / 100 < 99) m_val += 100;
      if (prev == S_IDLE) m_state = S_SET;
      else if (m_state == S_DONE) m_state = S_RUN;
    end
    m_done = (prev == S_DONE) && (m_state == S_DONE);
    m_run = (m_state == S_RUN);
  endtask

  task automatic tick(input bit clr, input bit dv, input int d, input bit mag, input bit add);
    clearn = clr;
    digit_valid = dv;
    digit = 4'(d);
    mag_on = mag;
`ifdef ADD_MINUTE_EN
    add_minute = add;
`endif
    @(posedge clk);
    model_step(clr, dv, d, mag, add);
    #1;
    digit_valid = 1'b0;
`ifdef ADD_MINUTE_EN
    add_minute = 1'b0;
`endif
  endtask

  task automatic enter4(input int v);
    int p[4] = '{1000, 100, 10, 1};
    for (int k = 0; k < 4; k++) tick(1, 1, (v / p[k]) % 10, 0, 0);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) tick(1, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clearn = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd5;
    mag_on = 1'b1;
`ifdef ADD_MINUTE_EN
    add_minute = 1'b1;
`endif
    repeat (2) @(posedge clk);
    m_state = S_IDLE;
    m_val = 0;
    m_presc = 0;
    m_done = 0;
    m_run = 0;
    #1;
    total++;
    if (obs !== mk(S_IDLE, 0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=%h", obs, mk(S_IDLE, 0, 0, 0));
    end
    resetn = 1'b1;
    digit_valid = 1'b0;
    mag_on = 1'b0;
`ifdef ADD_MINUTE_EN
    add_minute = 1'b0;
`endif
  endtask

  task automatic test_entry_and_first_second();
    tick(1, 1, 1, 0, 0);
    tick(1, 1, 2, 0, 0);
    tick(1, 1, 3, 0, 0);
    total++;
    if (obs !== mk(S_SET, 123, 0, 0)) begin
      bad++;
      $display("[TB] FAIL entry_123 got=%h want=%h", obs, mk(S_SET, 123, 0, 0));
    end
    tick(1, 0, 0, 1, 0);
    total++;
    if (obs !== mk(S_RUN, 123, 0, 1)) begin
      bad++;
      $display("[TB] FAIL set_to_run got=%h want=%h", obs, mk(S_RUN, 123, 0, 1));
    end
    run_cycles(3);
    total++;
    if (obs !== mk(S_RUN, 123, 0, 1)) begin
      bad++;
      $display("[TB] FAIL no_early_tick got=%h want=%h", obs, mk(S_RUN, 123, 0, 1));
    end
    run_cycles(1);
    total++;
    if (obs !== mk(S_RUN, 122, 0, 1)) begin
      bad++;
      $display("[TB] FAIL first_second got=%h want=%h", obs, mk(S_RUN, 122, 0, 1));
    end
    tick(0, 0, 0, 1, 0);
  endtask

  task automatic test_pause_resume();
    int cnt;
    enter4(10);
    tick(1, 0, 0, 1, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 0, 1, 0);
      cnt++;
    end
    total++;
    if (obs !== mk(S_RUN, 9, 0, 1)) begin
      bad++;
      $display("[TB] FAIL pause_pre got=%h want=%h", obs, mk(S_RUN, 9, 0, 1));
    end
    for (int k = 0; k < 20; k++) tick(1, 0, 0, 0, 0);
    total++;
    if (obs !== mk(S_SET, 9, 0, 0)) begin
      bad++;
      $display("[TB] FAIL paused got=%h want=%h", obs, mk(S_SET, 9, 0, 0));
    end
    tick(1, 0, 0, 1, 0);
    for (int k = 0; k < 100 && state !== 2'(S_DONE); k++) begin
      tick(1, 0, 0, 1, 0);
      cnt++;
    end
    total++;
    if (cnt != 40) begin
      bad++;
      $display("[TB] FAIL run_cycles_to_done got=%0d want=40", cnt);
    end
    total++;
    if (obs !== mk(S_DONE, 0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL done_edge got=%h want=%h", obs, mk(S_DONE, 0, 0, 0));
    end
    tick(1, 0, 0, 0, 0);
    total++;
    if (obs !== mk(S_DONE, 0, 1, 0)) begin
      bad++;
      $display("[TB] FAIL done_flag got=%h want=%h", obs, mk(S_DONE, 0, 1, 0));
    end
    tick(1, 0, 0, 1, 0);
    total++;
    if (obs !== mk(S_DONE, 0, 1, 0)) begin
      bad++;
      $display("[TB] FAIL done_ignores_mag got=%h want=%h", obs, mk(S_DONE, 0, 1, 0));
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_borrow();
    enter4(100);
    tick(1, 0, 0, 1, 0);
    run_cycles(TICKS);
    total++;
    if (obs !== mk(S_RUN, 59, 0, 1)) begin
      bad++;
      $display("[TB] FAIL borrow_0100 got=%h want=%h", obs, mk(S_RUN, 59, 0, 1));
    end
    tick(0, 0, 0, 0, 0);
    enter4(1000);
    tick(1, 0, 0, 1, 0);
    run_cycles(TICKS);
    total++;
    if (obs !== mk(S_RUN, 959, 0, 1)) begin
      bad++;
      $display("[TB] FAIL borrow_1000 got=%h want=%h", obs, mk(S_RUN, 959, 0, 1));
    end
    tick(0, 0, 0, 0, 0);
    enter4(90);
    tick(1, 0, 0, 1, 0);
    run_cycles(TICKS);
    total++;
    if (obs !== mk(S_RUN, 89, 0, 1)) begin
      bad++;
      $display("[TB] FAIL sec90_first got=%h want=%h", obs, mk(S_RUN, 89, 0, 1));
    end
    run_cycles(9 * TICKS);
    total++;
    if (obs !== mk(S_RUN, 80, 0, 1)) begin
      bad++;
      $display("[TB] FAIL sec90_ten got=%h want=%h", obs, mk(S_RUN, 80, 0, 1));
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_entry_rules();
    for (int k = 1; k <= 5; k++) tick(1, 1, k, 0, 0);
    total++;
    if (obs !== mk(S_SET, 2345, 0, 0)) begin
      bad++;
      $display("[TB] FAIL five_digits got=%h want=%h", obs, mk(S_SET, 2345, 0, 0));
    end
    tick(1, 1, 12, 0, 0);
    total++;
    if (obs !== mk(S_SET, 2345, 0, 0)) begin
      bad++;
      $display("[TB] FAIL digit_12 got=%h want=%h", obs, mk(S_SET, 2345, 0, 0));
    end
    tick(1, 0, 0, 1, 0);
    tick(1, 1, 5, 1, 0);
    total++;
    if (obs !== mk(S_RUN, 2345, 0, 1)) begin
      bad++;
      $display("[TB] FAIL digit_in_run got=%h want=%h", obs, mk(S_RUN, 2345, 0, 1));
    end
    tick(0, 0, 0, 1, 0);
    total++;
    if (obs !== mk(S_IDLE, 0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL clear_in_run got=%h want=%h", obs, mk(S_IDLE, 0, 0, 0));
    end
  endtask

  task automatic test_done_entry();
    enter4(1);
    tick(1, 0, 0, 1, 0);
    run_cycles(TICKS);
    tick(1, 0, 0, 0, 0);
    total++;
    if (obs !== mk(S_DONE, 0, 1, 0)) begin
      bad++;
      $display("[TB] FAIL done_reached got=%h want=%h", obs, mk(S_DONE, 0, 1, 0));
    end
    tick(1, 1, 7, 0, 0);
    total++;
    if (obs !== mk(S_SET, 7, 0, 0)) begin
      bad++;
      $display("[TB] FAIL done_digit7 got=%h want=%h", obs, mk(S_SET, 7, 0, 0));
    end
    enter4(1000);
    total++;
    if (obs !== mk(S_SET, 1000, 0, 0)) begin
      bad++;
      $display("[TB] FAIL load_1000 got=%h want=%h", obs, mk(S_SET, 1000, 0, 0));
    end
    enter4(0);
    total++;
    if (obs !== mk(S_IDLE, 0, 0, 0)) begin
      bad++;
      $display("[TB] FAIL zeros_idle got=%h want=%h", obs, mk(S_IDLE, 0, 0, 0));
    end
  endtask

`ifdef ADD_MINUTE_EN
  task automatic test_add_minute();
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    total++;
    if (obs !== mk(S_SET, 100, 0, 0)) begin
      bad++;
      $display("[TB] FAIL add_idle got=%h want=%h", obs, mk(S_SET, 100, 0, 0));
    end
    tick(0, 0, 0, 0, 0);
    enter4(9930);
    tick(1, 0, 0, 0, 1);
    total++;
    if (obs !== mk(S_SET, 9930, 0, 0)) begin
      bad++;
      $display("[TB] FAIL add_saturate got=%h want=%h", obs, mk(S_SET, 9930, 0, 0));
    end
    tick(0, 0, 0, 0, 0);
    enter4(1);
    tick(1, 0, 0, 1, 0);
    run_cycles(TICKS - 1);
    tick(1, 0, 0, 1, 1);
    total++;
    if (obs !== mk(S_RUN, 100, 0, 1)) begin
      bad++;
      $display("[TB] FAIL add_final_tick got=%h want=%h", obs, mk(S_RUN, 100, 0, 1));
    end
    tick(0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    bit clr, dv, mag, add;
    int d;
    mag = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      clr = ($urandom % 60) != 0;
      dv = ($urandom % 6) == 0;
      d = (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 3);
      if (($urandom % 12) == 0) mag = ~mag;
`ifdef ADD_MINUTE_EN
      add = ($urandom % 25) == 0;
`else
      add = 1'b0;
`endif
      tick(clr, dv, d, mag, add);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random_cycle%0d got=%h want=%h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    clearn = 1'b1;
    digit_valid = 1'b0;
    digit = 4'd0;
    mag_on = 1'b0;
`ifdef ADD_MINUTE_EN
    add_minute = 1'b0;
`endif
    #1;
    test_reset();
    test_entry_and_first_second();
    test_pause_resume();
    test_borrow();
    test_entry_rules();
    test_done_entry();
`ifdef ADD_MINUTE_EN
    test_add_minute();
`endif
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
